// File: rtl/regbank_wb_arbiter.sv
// Round-robin writeback arbiter for the register bank write port, with a pending-write scoreboard and RAW hazard flag.
// One cycle from grant to wr_*; ready is combinational, and hold freezes all grants.
module regbank_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [ADDR_W-1:0]      req0_addr,
    input  logic [DATA_W-1:0]      req0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [ADDR_W-1:0]      req1_addr,
    input  logic [DATA_W-1:0]      req1_data,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_addr,
    input  logic [ADDR_W-1:0]      src1,
    input  logic [ADDR_W-1:0]      src2,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic                   raw_stall,
    output logic                   issue_err
);

    localparam int NREG = 1 << ADDR_W;

    logic            prio;
    logic [NREG-1:0] busy_nxt;
    logic            issue_hit_wb;

    always_comb begin
        req0_ready = ~hold & req0_valid & (~req1_valid | ~prio);
        req1_ready = ~hold & req1_valid & (~req0_valid | prio);
    end

    // Priority passes to whichever requester lost, even when the grant was uncontested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            prio    <= 1'b0;
        end else if (req0_ready) begin
            wr_en   <= 1'b1;
            wr_addr <= req0_addr;
            wr_data <= req0_data;
            prio    <= 1'b1;
        end else if (req1_ready) begin
            wr_en   <= 1'b1;
            wr_addr <= req1_addr;
            wr_data <= req1_data;
            prio    <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Clear on the bank-write edge, then set; a same-index issue must win.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[wr_addr] = 1'b0;
        if (issue_valid)
            busy_nxt[issue_addr] = 1'b1;
    end

    assign issue_hit_wb = wr_en & (wr_addr == issue_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= '0;
            issue_err <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            issue_err <= issue_valid & busy[issue_addr] & ~issue_hit_wb;
        end
    end

    assign raw_stall = busy[src1] | busy[src2];

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: reset, single write, contention, hold, scoreboard and issue corners.
module tb_regbank_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_addr;
    logic [31:0] req1_data;
    logic        issue_valid;
    logic [3:0]  issue_addr;
    logic [3:0]  src1, src2;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] busy;
    logic        raw_stall;
    logic        issue_err;

    int n_checks = 0;
    int n_pass   = 0;

    regbank_wb_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .src1(src1), .src2(src2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .raw_stall(raw_stall), .issue_err(issue_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hold = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        issue_valid = 1'b0; issue_addr = '0; src1 = '0; src2 = '0;
        step(); step();
        check("rst_wr_en",   32'(wr_en),     32'd0);
        check("rst_wr_addr", 32'(wr_addr),   32'd0);
        check("rst_wr_data", wr_data,        32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_err",     32'(issue_err), 32'd0);
        reset = 1'b0;
        step();

        // Single uncontested write
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 32'hDEADBEEF;
        #1;
        check("single_rdy0", 32'(req0_ready), 32'd1);
        check("single_rdy1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        check("single_wr_en",   32'(wr_en),   32'd1);
        check("single_wr_addr", 32'(wr_addr), 32'd3);
        check("single_wr_data", wr_data,      32'hDEADBEEF);
        step();
        check("single_wr_en_off", 32'(wr_en),   32'd0);
        check("single_addr_hold", 32'(wr_addr), 32'd3);
        check("single_data_hold", wr_data,      32'hDEADBEEF);

        // Mid-stream reset: prio is 1 here, reset must bring it back to 0
        req0_valid = 1'b1; req0_addr = 4'd4; req0_data = 32'h1111;
        issue_valid = 1'b1; issue_addr = 4'd9;
        step();
        req0_valid = 1'b0; issue_valid = 1'b0;
        check("mid_wr_en",  32'(wr_en), 32'd1);
        check("mid_busy",   32'(busy),  32'h0200);
        reset = 1'b1;
        #1;
        check("async_wr_en", 32'(wr_en),     32'd0);
        check("async_busy",  32'(busy),      32'd0);
        check("async_err",   32'(issue_err), 32'd0);
        step();
        reset = 1'b0;

        // Contention: grants must alternate starting with req0
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'hA1;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont_rdy0_%0d", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_rdy1_%0d", i), 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check($sformatf("cont_wr_en_%0d", i),   32'(wr_en),   32'd1);
            check($sformatf("cont_wr_addr_%0d", i), 32'(wr_addr), (i % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("cont_wr_data_%0d", i), wr_data,      (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end

        // Hold freezes grants for 3 cycles
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold_rdy0_%0d", i), 32'(req0_ready), 32'd0);
            check($sformatf("hold_rdy1_%0d", i), 32'(req1_ready), 32'd0);
            step();
            check($sformatf("hold_wr_en_%0d", i), 32'(wr_en), 32'd0);
        end
        hold = 1'b0;
        #1;
        check("release_rdy0", 32'(req0_ready), 32'd1);
        check("release_rdy1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("release_wr_addr", 32'(wr_addr), 32'd1);
        step();

        // Scoreboard set by issue, cleared one edge after the writeback
        issue_valid = 1'b1; issue_addr = 4'd5; src1 = 4'd5; src2 = 4'd0;
        #1;
        check("sb_stall_pre", 32'(raw_stall), 32'd0);
        step();
        issue_valid = 1'b0;
        check("sb_busy_set", 32'(busy),      32'h0020);
        check("sb_stall",    32'(raw_stall), 32'd1);
        req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 32'h55;
        #1;
        check("sb_rdy1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        check("sb_wr_en",       32'(wr_en),     32'd1);
        check("sb_busy_on_wr",  32'(busy),      32'h0020);
        check("sb_stall_on_wr", 32'(raw_stall), 32'd1);
        step();
        check("sb_busy_clr",  32'(busy),      32'd0);
        check("sb_stall_clr", 32'(raw_stall), 32'd0);

        // Double issue to r7 raises a single-cycle error
        src1 = 4'd0; src2 = 4'd7;
        issue_valid = 1'b1; issue_addr = 4'd7;
        step();
        check("dbl_busy",  32'(busy),      32'h0080);
        check("dbl_err_0", 32'(issue_err), 32'd0);
        check("src2_stall", 32'(raw_stall), 32'd1);
        step();
        issue_valid = 1'b0;
        check("dbl_err_1", 32'(issue_err), 32'd1);
        step();
        check("dbl_err_2", 32'(issue_err), 32'd0);

        // Issue to r7 on the edge its writeback lands: set wins, no error
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 32'h77;
        step();
        req0_valid = 1'b0;
        check("same_wr_addr", 32'(wr_addr), 32'd7);
        issue_valid = 1'b1; issue_addr = 4'd7;
        step();
        issue_valid = 1'b0;
        check("same_busy", 32'(busy),      32'h0080);
        check("same_err",  32'(issue_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
